// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 3-bit-opcode CPU: instruction width,
// opcode encodings and instruction field positions.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;

    typedef enum logic [2:0] {
        OP_RTYPE = 3'b000,
        OP_ANDI  = 3'b001,
        OP_ORI   = 3'b010,
        OP_ADDI  = 3'b011,
        OP_SLTI  = 3'b100,
        OP_LW    = 3'b101,
        OP_SW    = 3'b110,
        OP_BNE   = 3'b111
    } opcode_e;

    localparam int unsigned OPC_MSB   = 15;
    localparam int unsigned OPC_LSB   = 13;
    localparam int unsigned RS_MSB    = 12;
    localparam int unsigned RS_LSB    = 11;
    localparam int unsigned RT_MSB    = 10;
    localparam int unsigned RT_LSB    = 9;
    localparam int unsigned RD_MSB    = 8;
    localparam int unsigned RD_LSB    = 7;
    localparam int unsigned FUNCT_MSB = 1;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_MSB   = 7;
    localparam int unsigned IMM_LSB   = 0;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: combinational read, synchronous write.
// Contents are deliberately not reset so a loaded program survives Reset.
module instr_mem
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_AW = 7
) (
    input  logic               clk,
    input  logic               wrEn,
    input  logic [IMEM_AW-1:0] wrAddr,
    input  logic [INSTR_W-1:0] wrData,
    input  logic [IMEM_AW-1:0] rdAddr,
    output logic [INSTR_W-1:0] rdData
);

    logic [INSTR_W-1:0] mem [0:(1 << IMEM_AW)-1];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/instruction_fetch_stage.sv
// CPU front end: PC register, instruction memory and the IF/ID pipeline
// register, with branch redirect/flush taking priority over stall.
module instruction_fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned    PC_W     = 16,
    parameter int unsigned    IMEM_AW  = 7,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [PC_W-1:0]    BranchTarget,
    input  logic               ImemWrEn,
    input  logic [IMEM_AW-1:0] ImemWrAddr,
    input  logic [INSTR_W-1:0] ImemWrData,
    output logic [PC_W-1:0]    Pc,
    output logic               IfIdValid,
    output logic [INSTR_W-1:0] IfIdInstr,
    output logic [PC_W-1:0]    IfIdPcPlus2,
    output logic [2:0]         Opcode,
    output logic [1:0]         Rs,
    output logic [1:0]         Rt,
    output logic [1:0]         Rd,
    output logic [1:0]         Funct,
    output logic [15:0]        ImmSext
);

    logic [INSTR_W-1:0] fetchWord;
    logic [PC_W-1:0]    pcPlus2;
    logic [PC_W-1:0]    targetAligned;

    instr_mem #(
        .IMEM_AW(IMEM_AW)
    ) uImem (
        .clk    (Clock),
        .wrEn   (ImemWrEn),
        .wrAddr (ImemWrAddr),
        .wrData (ImemWrData),
        .rdAddr (Pc[IMEM_AW:1]),
        .rdData (fetchWord)
    );

    assign pcPlus2       = Pc + PC_W'(2);
    assign targetAligned = BranchTarget & ~PC_W'(1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Pc          <= RESET_PC;
            IfIdValid   <= 1'b0;
            IfIdInstr   <= NOP_INSTR;
            IfIdPcPlus2 <= '0;
        end else if (BranchTaken) begin
            Pc          <= targetAligned;
            IfIdValid   <= 1'b0;
            IfIdInstr   <= NOP_INSTR;
            IfIdPcPlus2 <= '0;
        end else if (!Stall) begin
            Pc          <= pcPlus2;
            IfIdValid   <= 1'b1;
            IfIdInstr   <= fetchWord;
            IfIdPcPlus2 <= pcPlus2;
        end
    end

    assign Opcode  = IfIdInstr[OPC_MSB:OPC_LSB];
    assign Rs      = IfIdInstr[RS_MSB:RS_LSB];
    assign Rt      = IfIdInstr[RT_MSB:RT_LSB];
    assign Rd      = IfIdInstr[RD_MSB:RD_LSB];
    assign Funct   = IfIdInstr[FUNCT_MSB:FUNCT_LSB];
    assign ImmSext = {{8{IfIdInstr[IMM_MSB]}}, IfIdInstr[IMM_MSB:IMM_LSB]};

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a behavioural fetch model
// queues the expected IF/ID state per edge; a monitor compares after each edge.
module tb_instruction_fetch_stage;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [15:0] BranchTarget = '0;
    logic        ImemWrEn = 1'b0;
    logic [6:0]  ImemWrAddr = '0;
    logic [15:0] ImemWrData = '0;
    logic [15:0] Pc;
    logic        IfIdValid;
    logic [15:0] IfIdInstr;
    logic [15:0] IfIdPcPlus2;
    logic [2:0]  Opcode;
    logic [1:0]  Rs, Rt, Rd, Funct;
    logic [15:0] ImmSext;

    instruction_fetch_stage #(
        .PC_W(16),
        .IMEM_AW(7),
        .RESET_PC(16'h0000)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .ImemWrEn(ImemWrEn), .ImemWrAddr(ImemWrAddr), .ImemWrData(ImemWrData),
        .Pc(Pc), .IfIdValid(IfIdValid), .IfIdInstr(IfIdInstr),
        .IfIdPcPlus2(IfIdPcPlus2), .Opcode(Opcode), .Rs(Rs), .Rt(Rt),
        .Rd(Rd), .Funct(Funct), .ImmSext(ImmSext)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int unsigned pc;
        int unsigned instr;
        int unsigned pcp2;
        bit          valid;
    } exp_t;

    exp_t        sb[$];
    int unsigned mMem [128];
    int unsigned mPc, mInstr, mPcp2;
    bit          mValid;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = 0; mInstr = 0; mPcp2 = 0; mValid = 0;
    endtask

    // One clock of stimulus: drive inputs at the falling edge and queue what
    // the IF/ID state must look like after the next rising edge.
    task automatic cycle(input bit st, input bit br, input int unsigned tgt,
                         input bit we, input int unsigned wa, input int unsigned wd);
        exp_t e;
        @(negedge Clock);
        Stall = st; BranchTaken = br; BranchTarget = 16'(tgt);
        ImemWrEn = we; ImemWrAddr = 7'(wa); ImemWrData = 16'(wd);
        if (br) begin
            mPc = (tgt / 2) * 2;
            mInstr = 0; mPcp2 = 0; mValid = 0;
        end else if (!st) begin
            mInstr = mMem[(mPc / 2) % 128];
            mPcp2  = (mPc + 2) % 65536;
            mValid = 1;
            mPc    = mPcp2;
        end
        if (we) mMem[wa % 128] = wd;
        e.pc = mPc; e.instr = mInstr; e.pcp2 = mPcp2; e.valid = mValid;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, $urandom_range(0, 65535), 0, 0, 0);
    endtask

    // Monitor: after each rising edge compare whatever expectation is queued.
    initial begin
        exp_t e;
        int unsigned imm;
        forever begin
            @(posedge Clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("Pc", Pc, e.pc);
                chk("IfIdValid", IfIdValid, e.valid);
                chk("IfIdInstr", IfIdInstr, e.instr);
                chk("IfIdPcPlus2", IfIdPcPlus2, e.pcp2);
                chk("Opcode", Opcode, e.instr / 8192);
                chk("Rs", Rs, (e.instr / 2048) % 4);
                chk("Rt", Rt, (e.instr / 512) % 4);
                chk("Rd", Rd, (e.instr / 128) % 4);
                chk("Funct", Funct, e.instr % 4);
                imm = e.instr % 256;
                chk("ImmSext", ImmSext, (imm >= 128) ? imm + 16'hFF00 : imm);
            end
        end
    end

    initial begin
        int unsigned w;
        bit st, br, we;
        // Preload the whole memory while Reset is held.
        for (int i = 0; i < 128; i++) begin
            case (i)
                0:       w = 16'h2041;
                1:       w = 16'h6085;
                2:       w = 16'hA0C2;
                3:       w = 16'hC0C4;
                16:      w = 16'h5A3C;
                127:     w = 16'hE9F7;
                default: w = $urandom_range(0, 65535);
            endcase
            @(negedge Clock);
            ImemWrEn = 1'b1; ImemWrAddr = 7'(i); ImemWrData = 16'(w);
            mMem[i] = w;
        end
        @(negedge Clock);
        ImemWrEn = 1'b0;
        #1;
        chk("reset Pc", Pc, 0);
        chk("reset IfIdValid", IfIdValid, 0);
        chk("reset IfIdInstr", IfIdInstr, 0);
        chk("reset IfIdPcPlus2", IfIdPcPlus2, 0);
        @(posedge Clock);
        #2 Reset = 1'b0;
        modelReset();

        // Sequential fetch, 3-cycle stall at Pc=4, resume.
        idle(2);
        for (int i = 0; i < 3; i++) cycle(1, 0, 16'h1234, 0, 0, 0);
        idle(3);
        // Branch flush to 0x0021, then fetch imem[16].
        cycle(0, 1, 16'h0021, 0, 0, 0);
        idle(2);
        // Branch beats stall.
        cycle(1, 1, 16'h0021, 0, 0, 0);
        idle(2);
        // Wrap and alias: 0xFFFE fetches word 127, then Pc wraps to 0.
        cycle(0, 1, 16'hFFFF, 0, 0, 0);
        idle(2);
        // Write the word being fetched in the same cycle: old data returned.
        cycle(0, 1, 16'h0040, 0, 0, 0);
        cycle(0, 0, 0, 1, 32, 16'hBEEF);
        cycle(0, 1, 16'h0040, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 4) == 0);
            cycle(st, br, $urandom_range(0, 65535), we,
                  $urandom_range(0, 127), $urandom_range(0, 65535));
        end
        idle(2);

        // Asynchronous reset between edges while IF/ID holds a valid word.
        @(posedge Clock);
        #3;
        chk("pre-reset IfIdValid", IfIdValid, 1);
        Reset = 1'b1;
        #1;
        chk("async reset Pc", Pc, 0);
        chk("async reset IfIdValid", IfIdValid, 0);
        chk("async reset IfIdInstr", IfIdInstr, 0);
        chk("async reset IfIdPcPlus2", IfIdPcPlus2, 0);
        @(posedge Clock);
        #2 Reset = 1'b0;
        modelReset();
        idle(4);

        @(posedge Clock);
        #3;
        chk("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete by %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
